// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag generator for an async CDC FIFO.
// Optional almost-full output enabled by defining FIFO_ALMOST_FULL_EN.
module fifo_wptr_full #(
  parameter int addrsize = 4
`ifdef FIFO_ALMOST_FULL_EN
  , parameter int AF_THRESH = 12
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                winc,
  input  logic [addrsize:0]   wq2_rptr,
  output logic [addrsize-1:0] waddr,
  output logic [addrsize:0]   wptr,
  output logic                wfull,
  output logic                wovf
`ifdef FIFO_ALMOST_FULL_EN
  , output logic              wafull
`endif
);

  logic [addrsize:0] wbin_q, wbin_d;
  logic [addrsize:0] wptr_q, wptr_d;
  logic              wfull_q, wfull_d;
  logic              wovf_q, wovf_d;
  logic              wen;
  logic [addrsize:0] full_cmp;

  assign wen    = winc & ~wfull_q;
  assign wbin_d = wbin_q + (addrsize+1)'(wen);
  assign wptr_d = (wbin_d >> 1) ^ wbin_d;

  // Full when the write pointer has lapped the read pointer: in Gray code
  // that means the two MSBs inverted and the remaining bits equal.
  assign full_cmp = {~wq2_rptr[addrsize:addrsize-1], wq2_rptr[addrsize-2:0]};
  assign wfull_d  = (wptr_d == full_cmp);
  assign wovf_d   = wovf_q | (winc & wfull_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      wfull_q <= 1'b0;
      wovf_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      wfull_q <= wfull_d;
      wovf_q  <= wovf_d;
    end
  end

  assign waddr = wbin_q[addrsize-1:0];
  assign wptr  = wptr_q;
  assign wfull = wfull_q;
  assign wovf  = wovf_q;

`ifdef FIFO_ALMOST_FULL_EN
  logic [addrsize:0] rbin;
  logic [addrsize:0] level;
  logic              wafull_q, wafull_d;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  assign rbin[addrsize] = wq2_rptr[addrsize];
  generate
    for (genvar gi = addrsize - 1; gi >= 0; gi--) begin : g_gray2bin
      assign rbin[gi] = rbin[gi+1] ^ wq2_rptr[gi];
    end
  endgenerate

  assign level    = wbin_d - rbin;
  assign wafull_d = (level >= (addrsize+1)'(AF_THRESH));

  always_ff @(posedge clk) begin
    if (rst) wafull_q <= 1'b0;
    else     wafull_q <= wafull_d;
  end

  assign wafull = wafull_q;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full: directed vector table, hand sequences,
// and randomized traffic against an occupancy-count reference model.
module tb_fifo_wptr_full;

  localparam int AS    = 4;
  localparam int DEPTH = 1 << AS;
  localparam int AF    = 12;

  logic          clk;
  logic          rst;
  logic          winc;
  logic [AS:0]   wq2_rptr;
  logic [AS-1:0] waddr;
  logic [AS:0]   wptr;
  logic          wfull;
  logic          wovf;
`ifdef FIFO_ALMOST_FULL_EN
  logic          wafull;
`endif

  int checks = 0;
  int errors = 0;

  fifo_wptr_full #(.addrsize(AS)) dut (
    .clk(clk),
    .rst(rst),
    .winc(winc),
    .wq2_rptr(wq2_rptr),
    .waddr(waddr),
    .wptr(wptr),
    .wfull(wfull),
    .wovf(wovf)
`ifdef FIFO_ALMOST_FULL_EN
    , .wafull(wafull)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       winc;
    logic [4:0] rptr;
    logic [4:0] e_wptr;
    logic [3:0] e_waddr;
    logic       e_full;
    logic       e_ovf;
  } vec_t;

  function automatic logic [4:0] to_gray(int n);
    logic [4:0] b;
    b = 5'(n % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs, take one edge, sample shortly after it.
  task automatic step(logic r, logic w, logic [4:0] rp);
    rst = r; winc = w; wq2_rptr = rp;
    @(posedge clk);
    #1;
  endtask

  vec_t vec[22];
  int   gseq[16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 24};

  initial begin
    int n;
    int wcnt, rcnt, occ;
    logic m_full, m_ovf, r, w;
    logic [4:0] prev, hist[$];
    bit wrap_seen, full_seen;

    rst = 1'b1; winc = 1'b1; wq2_rptr = '0;

    // Directed table: reset with winc high, fill, overflow, release, refill.
    n = 0;
    for (int i = 0; i < 2; i++) vec[n++] = '{1'b1, 1'b1, 5'd0, 5'd0, 4'd0, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++)
      vec[n++] = '{1'b0, 1'b1, 5'd0, 5'(gseq[i]), 4'((i + 1) % 16), (i == 15), 1'b0};
    for (int i = 0; i < 2; i++) vec[n++] = '{1'b0, 1'b1, 5'd0, 5'b11000, 4'd0, 1'b1, 1'b1};
    vec[n++] = '{1'b0, 1'b0, 5'b00001, 5'b11000, 4'd0, 1'b0, 1'b1};
    vec[n++] = '{1'b0, 1'b1, 5'b00001, 5'b11001, 4'd1, 1'b1, 1'b1};

    for (int i = 0; i < n; i++) begin
      step(vec[i].rst, vec[i].winc, vec[i].rptr);
      $display("vec %0d rst=%0b winc=%0b rptr=%05b -> wptr=%05b waddr=%0d full=%0b ovf=%0b",
               i, vec[i].rst, vec[i].winc, vec[i].rptr, wptr, waddr, wfull, wovf);
      chk("vec_wptr",  int'(wptr),  int'(vec[i].e_wptr));
      chk("vec_waddr", int'(waddr), int'(vec[i].e_waddr));
      chk("vec_wfull", int'(wfull), int'(vec[i].e_full));
      chk("vec_wovf",  int'(wovf),  int'(vec[i].e_ovf));
    end

    // Wrap sequence: read pointer follows the write pointer two clocks late.
    step(1'b1, 1'b0, 5'd0);
    hist = '{5'd0, 5'd0};
    prev = wptr;
    wrap_seen = 0; full_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, hist[0]);
      void'(hist.pop_front());
      hist.push_back(wptr);
      $display("wrap %0d wptr=%05b waddr=%0d full=%0b", i, wptr, waddr, wfull);
      chk("wrap_onebit", $countones(prev ^ wptr), 1);
      chk("wrap_wptr", int'(wptr), int'(to_gray(i + 1)));
      if (prev == 5'b10000 && wptr == 5'b00000) wrap_seen = 1;
      if (wfull) full_seen = 1;
      prev = wptr;
    end
    chk("wrap_seen", int'(wrap_seen), 1);
    chk("wrap_nofull", int'(full_seen), 0);
    chk("wrap_noovf", int'(wovf), 0);

`ifdef FIFO_ALMOST_FULL_EN
    step(1'b1, 1'b0, 5'd0);
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1, 5'd0);
      $display("afull %0d wafull=%0b", i, wafull);
      chk("afull_level", int'(wafull), int'(i >= AF));
    end
`endif

    // Reset in the middle of a burst clears everything on that edge.
    step(1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 5'd0);
    step(1'b1, 1'b1, 5'd0);
    $display("midrst wptr=%05b waddr=%0d full=%0b ovf=%0b", wptr, waddr, wfull, wovf);
    chk("midrst_wptr", int'(wptr), 0);
    chk("midrst_waddr", int'(waddr), 0);
    chk("midrst_wfull", int'(wfull), 0);
    chk("midrst_wovf", int'(wovf), 0);
`ifdef FIFO_ALMOST_FULL_EN
    chk("midrst_wafull", int'(wafull), 0);
`endif
    step(1'b0, 1'b1, 5'd0);
    chk("midrst_first", int'(wptr), 1);

    // Randomized traffic against an occupancy model: counts, not pointers.
    wcnt = 1; rcnt = 0; m_full = 0; m_ovf = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      r = ($urandom_range(0, 99) == 0);
      w = ($urandom_range(0, 99) < 70);
      if (r) rcnt = 0;
      else if (rcnt < wcnt && $urandom_range(0, 99) < 35) rcnt++;
      step(r, w, to_gray(rcnt));
      if (r) begin
        wcnt = 0; m_full = 0; m_ovf = 0;
      end else begin
        if (w && m_full) m_ovf = 1;
        if (w && !m_full) wcnt++;
        m_full = ((wcnt - rcnt) == DEPTH);
      end
      occ = wcnt - rcnt;
      $display("rand %0d rst=%0b winc=%0b occ=%0d wptr=%05b full=%0b ovf=%0b",
               cyc, r, w, occ, wptr, wfull, wovf);
      chk("rand_wptr",  int'(wptr),  int'(to_gray(wcnt)));
      chk("rand_waddr", int'(waddr), wcnt % DEPTH);
      chk("rand_wfull", int'(wfull), int'(m_full));
      chk("rand_wovf",  int'(wovf),  int'(m_ovf));
`ifdef FIFO_ALMOST_FULL_EN
      chk("rand_wafull", int'(wafull), int'(!r && occ >= AF));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
